frame_phase_mux: RTL and testbench

Time-multiplexes one 40 MHz frame into four quarter-width slices at 160 MHz. The phase is aligned by the one-cycle `strobe4x` pulse that marks each rising edge of the 40 MHz clock, as produced by the logic-accessible-clock stage. It sits directly downstream of that stage, between the 40 MHz S-bit/partition registers and the 160 MHz cluster-finding and sorting logic. It also monitors strobe periodicity, reports lock, and counts alignment errors.

---
 rtl/frame_phase_mux.sv | 152 +++++++++++++++
 tb/tb_frame_phase_mux.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_phase_mux.sv
// frame_phase_mux: slices a 40 MHz frame into four quarter-width
// 160 MHz beats aligned to strobe4x, with lock and error tracking.
module frame_phase_mux #(
  parameter int MXIN        = 192,
  parameter int LOCK_COUNT  = 8,
  parameter int ERRCNT_BITS = 8
) (
  input  logic                   clock4x,
  input  logic                   reset,
  input  logic                   strobe4x,
  input  logic [MXIN-1:0]        data_in,
  output logic [MXIN/4-1:0]      data_out,
  output logic [1:0]             phase,
  output logic                   valid,
  output logic                   locked,
  output logic [ERRCNT_BITS-1:0] err_cnt
);

  localparam int Q = MXIN / 4;
  localparam logic [7:0] GOOD_LAST = 8'(LOCK_COUNT - 1);
  localparam logic [ERRCNT_BITS-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKING  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [MXIN-1:0]        hold_q, hold_d;
  logic [Q-1:0]           data_q, data_d;
  logic [1:0]             ph_q, ph_d;
  logic [7:0]             good_q, good_d;
  logic                   fok_q, fok_d;
  logic                   locked_q, locked_d;
  logic [ERRCNT_BITS-1:0] err_q, err_d;

  logic       good_ev;
  logic       early_ev;
  logic       miss_ev;
  logic       err_inc;
  logic [1:0] ph_nxt;

  // classify this edge's strobe against the phase before the edge
  always_comb begin
    good_ev  = strobe4x & (ph_q == 2'd3);
    early_ev = strobe4x & (ph_q != 2'd3);
    miss_ev  = ~strobe4x & (ph_q == 2'd3);
  end

  // capture on strobe, otherwise step through the held frame
  always_comb begin
    hold_d = hold_q;
    ph_nxt = ph_q + 2'd1;
    ph_d   = ph_nxt;
    data_d = data_q;
    if (strobe4x) begin
      hold_d = data_in;
      ph_d   = 2'd0;
      data_d = data_in[Q-1:0];
    end else begin
      case (ph_nxt)
        2'd0:    data_d = hold_q[Q-1:0];
        2'd1:    data_d = hold_q[2*Q-1:Q];
        2'd2:    data_d = hold_q[3*Q-1:2*Q];
        default: data_d = hold_q[4*Q-1:3*Q];
      endcase
    end
  end

  // lock state machine: next state and good-strobe run length
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_inc = 1'b0;
    case (state_q)
      ST_UNLOCKED: begin
        if (strobe4x) begin
          state_d = ST_LOCKING;
          good_d  = 8'd0;
        end
      end
      ST_LOCKING: begin
        if (good_ev) begin
          if (good_q == GOOD_LAST) begin
            state_d = ST_LOCKED;
          end else begin
            good_d = good_q + 8'd1;
          end
        end else if (early_ev) begin
          good_d = 8'd0;
        end else if (miss_ev) begin
          state_d = ST_UNLOCKED;
        end
      end
      ST_LOCKED: begin
        if (early_ev || miss_ev) begin
          state_d = ST_UNLOCKED;
          err_inc = 1'b1;
        end
      end
      default: begin
        state_d = ST_UNLOCKED;
      end
    endcase
  end

  // frame-valid flag, lock flag and saturating error count
  always_comb begin
    fok_d    = fok_q;
    locked_d = (state_d == ST_LOCKED);
    err_d    = err_q;
    if (strobe4x) begin
      fok_d = (state_d == ST_LOCKED);
    end else if (miss_ev) begin
      fok_d = 1'b0;
    end
    if (err_inc && (err_q != ERR_MAX)) begin
      err_d = err_q + 1'b1;
    end
  end

  // state registers; reset wins over a coincident strobe
  always_ff @(posedge clock4x) begin
    if (reset) begin
      state_q  <= ST_UNLOCKED;
      hold_q   <= '0;
      data_q   <= '0;
      ph_q     <= 2'd0;
      good_q   <= 8'd0;
      fok_q    <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      data_q   <= data_d;
      ph_q     <= ph_d;
      good_q   <= good_d;
      fok_q    <= fok_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign data_out = data_q;
  assign phase    = ph_q;
  assign valid    = fok_q;
  assign locked   = locked_q;
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_frame_phase_mux.sv
// tb_frame_phase_mux: directed and random strobe patterns on two
// instances, checked cycle by cycle against a queue-fed scoreboard.
module tb_frame_phase_mux;

  localparam int MX = 192;
  localparam int Q  = MX / 4;
  localparam int LC_A = 8;
  localparam int EB_A = 8;
  localparam int LC_B = 3;
  localparam int EB_B = 2;

  typedef struct packed {
    logic [Q-1:0] d;
    logic [1:0]   ph;
    logic [1:0]   v;
    logic [1:0]   l;
    logic [7:0]   e0;
    logic [7:0]   e1;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          stb;
  logic [MX-1:0] din;

  logic [Q-1:0]  a_d, b_d;
  logic [1:0]    a_ph, b_ph;
  logic          a_v, b_v, a_l, b_l;
  logic [EB_A-1:0] a_e;
  logic [EB_B-1:0] b_e;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;
  exp_t q[$];

  frame_phase_mux #(.MXIN(MX), .LOCK_COUNT(LC_A), .ERRCNT_BITS(EB_A)) u_a (
    .clock4x(clk), .reset(rst), .strobe4x(stb), .data_in(din),
    .data_out(a_d), .phase(a_ph), .valid(a_v), .locked(a_l),
    .err_cnt(a_e)
  );

  frame_phase_mux #(.MXIN(MX), .LOCK_COUNT(LC_B), .ERRCNT_BITS(EB_B)) u_b (
    .clock4x(clk), .reset(rst), .strobe4x(stb), .data_in(din),
    .data_out(b_d), .phase(b_ph), .valid(b_v), .locked(b_l),
    .err_cnt(b_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: age = cycles since last capture (or reset)
  int            age;
  logic [MX-1:0] hold_m;
  bit            lk[2];
  bit            lking[2];
  bit            vld[2];
  int            streak[2];
  int            err[2];
  int            lcnt[2] = '{LC_A, LC_B};
  int            emax[2] = '{(1 << EB_A) - 1, (1 << EB_B) - 1};

  always @(posedge clk) begin
    exp_t e;
    bit due;
    cyc_n++;
    if (rst) begin
      age = 0;
      hold_m = '0;
      for (int k = 0; k < 2; k++) begin
        lk[k] = 0; lking[k] = 0; vld[k] = 0;
        streak[k] = 0; err[k] = 0;
      end
    end else begin
      due = (age % 4) == 3;
      for (int k = 0; k < 2; k++) begin
        if (stb) begin
          if (!lk[k] && !lking[k]) begin
            lking[k] = 1;
            streak[k] = 0;
          end else if (due) begin
            if (lking[k]) begin
              streak[k]++;
              if (streak[k] >= lcnt[k]) begin
                lking[k] = 0;
                lk[k] = 1;
              end
            end
          end else if (lk[k]) begin
            err[k]++;
            lk[k] = 0;
          end else begin
            streak[k] = 0;
          end
          vld[k] = lk[k];
        end else if (due) begin
          if (lk[k]) err[k]++;
          lk[k] = 0;
          lking[k] = 0;
          vld[k] = 0;
        end
      end
      if (stb) begin
        hold_m = din;
        age = 0;
      end else begin
        age++;
      end
    end
    e.d  = hold_m[(age % 4) * Q +: Q];
    e.ph = 2'(age % 4);
    e.v  = {vld[1], vld[0]};
    e.l  = {lk[1], lk[0]};
    e.e0 = 8'(err[0] > emax[0] ? emax[0] : err[0]);
    e.e1 = 8'(err[1] > emax[1] ? emax[1] : err[1]);
    q.push_back(e);
  end

  // monitor: one comparison per instance per output cycle
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_cmp++;
      if (a_d !== e.d || a_ph !== e.ph || a_v !== e.v[0] ||
          a_l !== e.l[0] || a_e !== e.e0[EB_A-1:0]) begin
        n_bad++;
        $display("FAIL dutA cyc %0d: got d=%h ph=%0d v=%b l=%b e=%0d want d=%h ph=%0d v=%b l=%b e=%0d",
                 cyc_n, a_d, a_ph, a_v, a_l, a_e,
                 e.d, e.ph, e.v[0], e.l[0], e.e0);
      end
      n_cmp++;
      if (b_d !== e.d || b_ph !== e.ph || b_v !== e.v[1] ||
          b_l !== e.l[1] || b_e !== e.e1[EB_B-1:0]) begin
        n_bad++;
        $display("FAIL dutB cyc %0d: got d=%h ph=%0d v=%b l=%b e=%0d want d=%h ph=%0d v=%b l=%b e=%0d",
                 cyc_n, b_d, b_ph, b_v, b_l, b_e,
                 e.d, e.ph, e.v[1], e.l[1], e.e1);
      end
    end
  end

  function automatic logic [MX-1:0] rnd_frame();
    return {$urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom};
  endfunction

  task automatic cyc(input logic s, input logic r);
    stb = s;
    rst = r;
    din = rnd_frame();
    @(negedge clk);
  endtask

  task automatic frames(input int n, input int per);
    repeat (n) begin
      cyc(1'b1, 1'b0);
      repeat (per - 1) cyc(1'b0, 1'b0);
    end
  endtask

  initial begin
    int r;
    // reset with strobe toggling
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    // clean lock sequence
    frames(12, 4);
    // early strobe at ph==1 while locked, then re-lock
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    frames(12, 4);
    // one missing strobe while locked, then re-lock
    cyc(1'b1, 1'b0);
    repeat (7) cyc(1'b0, 1'b0);
    frames(12, 4);
    // reset mid-frame at phase 2 while locked
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b1);
    frames(3, 4);
    // repeated error/re-lock cycles to saturate the narrow counter
    repeat (6) begin
      frames(6, 4);
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
    end
    frames(4, 4);
    // random strobe spacing with occasional reset
    repeat (500) begin
      r = $urandom_range(0, 99);
      if (r < 2) cyc(1'b0, 1'b1);
      else if (r < 85) frames(1, 4);
      else frames(1, $urandom_range(1, 8));
    end
    cyc(1'b0, 1'b0);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: pending=%0d want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
